// File: rtl/syn_gpu_pkg.sv
// Shared FSM type and default widths for the GPU fill-stack blocks.
package syn_gpu_pkg;

    localparam int SYN_GPU_X_W    = 10;
    localparam int SYN_GPU_Y_W    = 10;
    localparam int SYN_GPU_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_REQ  = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } ff_sched_st_t;

endpackage

// File: rtl/syn_gpu_ff_stack_sched.sv
// Fill-stack push/pop sequencer: one SRAM word per op; push >= 2 cycles, pop returns data 1 cycle after mem_rdata_vld.
// Stalls requests (rdy low) outside IDLE or when full/empty; holds mem_req and its address/data until mem_ack.
module syn_gpu_ff_stack_sched
    import syn_gpu_pkg::*;
#(
    parameter int P_X_W      = SYN_GPU_X_W,
    parameter int P_Y_W      = SYN_GPU_Y_W,
    parameter int P_DATA_W   = SYN_GPU_DATA_W,
    parameter int P_OCC_W    = 16,
    parameter int P_POP_PRIO = 1,
    parameter int P_RD_TMO   = 255
) (
    input  logic                clk_ir,
    input  logic                rst_sync,
    input  logic                push_req,
    input  logic [P_DATA_W-1:0] push_data,
    output logic                push_rdy,
    input  logic                pop_req,
    output logic                pop_rdy,
    output logic [P_DATA_W-1:0] pop_data,
    output logic                pop_data_vld,
    output logic                lf_wr_en,
    output logic                lf_rd_en,
    input  logic [P_X_W-1:0]    lf_waddr_x,
    input  logic [P_Y_W-1:0]    lf_waddr_y,
    input  logic [P_X_W-1:0]    lf_raddr_x,
    input  logic [P_Y_W-1:0]    lf_raddr_y,
    input  logic                lf_full,
    input  logic                lf_empty,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [P_X_W-1:0]    mem_addr_x,
    output logic [P_Y_W-1:0]    mem_addr_y,
    output logic [P_DATA_W-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [P_DATA_W-1:0] mem_rdata,
    input  logic                mem_rdata_vld,
    output logic                busy,
    output logic [P_OCC_W-1:0]  occ,
    output logic                err_tmo
);

    localparam int                 TMO_W    = (P_RD_TMO > 1) ? $clog2(P_RD_TMO + 1) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(P_RD_TMO - 1);
    localparam logic               POP_PRIO = (P_POP_PRIO != 0);
    localparam logic [P_OCC_W-1:0] OCC_MAX  = '1;

    ff_sched_st_t        state_q, state_d;
    logic [P_X_W-1:0]    addr_x_q;
    logic [P_Y_W-1:0]    addr_y_q;
    logic [P_DATA_W-1:0] wdata_q;
    logic [P_DATA_W-1:0] pop_data_q;
    logic                pop_data_vld_q;
    logic [P_OCC_W-1:0]  occ_q, occ_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                err_tmo_q;
    logic                is_idle, push_acc, pop_acc, rd_done, rd_tmo;

    // Priority is resolved in the ready terms, so push_acc and pop_acc are mutually exclusive.
    assign is_idle  = (state_q == ST_IDLE);
    assign push_rdy = is_idle & ~lf_full  & ~(POP_PRIO & pop_req & ~lf_empty);
    assign pop_rdy  = is_idle & ~lf_empty & ~(~POP_PRIO & push_req & ~lf_full);
    assign push_acc = push_req & push_rdy;
    assign pop_acc  = pop_req & pop_rdy;

    always_comb begin
        state_d   = state_q;
        lf_wr_en  = 1'b0;
        lf_rd_en  = 1'b0;
        rd_done   = 1'b0;
        rd_tmo    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_acc)       state_d = ST_RD_REQ;
                else if (push_acc) state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (mem_ack) begin
                    lf_wr_en = ~rst_sync;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (mem_ack) begin
                    lf_rd_en = ~rst_sync;
                    state_d  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rdata_vld) begin
                    rd_done = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rd_tmo  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        occ_d = occ_q;
        if (lf_wr_en && (occ_q != OCC_MAX))  occ_d = occ_q + 1'b1;
        else if (lf_rd_en && (occ_q != '0)) occ_d = occ_q - 1'b1;

        tmo_cnt_d = (state_q == ST_RD_WAIT) ? tmo_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state_q        <= ST_IDLE;
            addr_x_q       <= '0;
            addr_y_q       <= '0;
            wdata_q        <= '0;
            pop_data_q     <= '0;
            pop_data_vld_q <= 1'b0;
            occ_q          <= '0;
            tmo_cnt_q      <= '0;
            err_tmo_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            occ_q          <= occ_d;
            tmo_cnt_q      <= tmo_cnt_d;
            pop_data_vld_q <= rd_done;
            if (push_acc) begin
                wdata_q  <= push_data;
                addr_x_q <= lf_waddr_x;
                addr_y_q <= lf_waddr_y;
            end
            if (pop_acc) begin
                addr_x_q <= lf_raddr_x;
                addr_y_q <= lf_raddr_y;
            end
            if (rd_done) pop_data_q <= mem_rdata;
            if (rd_tmo)  err_tmo_q  <= 1'b1;
        end
    end

    assign mem_req      = (state_q == ST_WR_REQ) | (state_q == ST_RD_REQ);
    assign mem_wr       = (state_q == ST_WR_REQ);
    assign mem_addr_x   = addr_x_q;
    assign mem_addr_y   = addr_y_q;
    assign mem_wdata    = wdata_q;
    assign pop_data     = pop_data_q;
    assign pop_data_vld = pop_data_vld_q;
    assign busy         = ~is_idle;
    assign occ          = occ_q;
    assign err_tmo      = err_tmo_q;

endmodule

// File: tb/tb_syn_gpu_ff_stack_sched.sv
// Bench: LIFO pointer/SRAM environment driven per transaction, checked against a queue model of the stack.
module tb_syn_gpu_ff_stack_sched;

    localparam int XW = 10, YW = 10, DW = 32, OW = 16, TMO = 8, DEPTH = 6;

    logic          clk = 1'b0;
    logic          rst_sync, push_req, pop_req, mem_ack, mem_rdata_vld;
    logic [DW-1:0] push_data, mem_rdata;
    logic [XW-1:0] lf_waddr_x, lf_raddr_x;
    logic [YW-1:0] lf_waddr_y, lf_raddr_y;
    logic          lf_full, lf_empty;

    logic          push_rdy, pop_rdy, pop_data_vld, lf_wr_en, lf_rd_en, mem_req, mem_wr, busy, err_tmo;
    logic [DW-1:0] pop_data, mem_wdata;
    logic [XW-1:0] mem_addr_x;
    logic [YW-1:0] mem_addr_y;
    logic [OW-1:0] occ;

    logic          b_push_rdy, b_pop_rdy, b_pop_data_vld, b_lf_wr_en, b_lf_rd_en, b_mem_req, b_mem_wr, b_busy, b_err_tmo;
    logic [DW-1:0] b_pop_data, b_mem_wdata;
    logic [XW-1:0] b_mem_addr_x;
    logic [YW-1:0] b_mem_addr_y;
    logic [OW-1:0] b_occ;

    int            ptr = 0;
    logic          full_force = 1'b0;
    int            checks = 0, failures = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sram [logic [19:0]];

    always #5 clk = ~clk;

    assign lf_waddr_x = XW'(ptr * 5 + 3);
    assign lf_waddr_y = YW'(ptr + 100);
    assign lf_raddr_x = XW'((ptr - 1) * 5 + 3);
    assign lf_raddr_y = YW'(ptr - 1 + 100);
    assign lf_full    = full_force | (ptr >= DEPTH);
    assign lf_empty   = (ptr == 0);

    syn_gpu_ff_stack_sched #(.P_X_W(XW), .P_Y_W(YW), .P_DATA_W(DW), .P_OCC_W(OW),
                             .P_POP_PRIO(1), .P_RD_TMO(TMO)) dut (
        .clk_ir(clk), .rst_sync(rst_sync),
        .push_req(push_req), .push_data(push_data), .push_rdy(push_rdy),
        .pop_req(pop_req), .pop_rdy(pop_rdy), .pop_data(pop_data), .pop_data_vld(pop_data_vld),
        .lf_wr_en(lf_wr_en), .lf_rd_en(lf_rd_en),
        .lf_waddr_x(lf_waddr_x), .lf_waddr_y(lf_waddr_y), .lf_raddr_x(lf_raddr_x), .lf_raddr_y(lf_raddr_y),
        .lf_full(lf_full), .lf_empty(lf_empty),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr_x(mem_addr_x), .mem_addr_y(mem_addr_y),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld),
        .busy(busy), .occ(occ), .err_tmo(err_tmo)
    );

    syn_gpu_ff_stack_sched #(.P_X_W(XW), .P_Y_W(YW), .P_DATA_W(DW), .P_OCC_W(OW),
                             .P_POP_PRIO(0), .P_RD_TMO(TMO)) dut_push_prio (
        .clk_ir(clk), .rst_sync(rst_sync),
        .push_req(push_req), .push_data(push_data), .push_rdy(b_push_rdy),
        .pop_req(pop_req), .pop_rdy(b_pop_rdy), .pop_data(b_pop_data), .pop_data_vld(b_pop_data_vld),
        .lf_wr_en(b_lf_wr_en), .lf_rd_en(b_lf_rd_en),
        .lf_waddr_x(lf_waddr_x), .lf_waddr_y(lf_waddr_y), .lf_raddr_x(lf_raddr_x), .lf_raddr_y(lf_raddr_y),
        .lf_full(lf_full), .lf_empty(lf_empty),
        .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_addr_x(b_mem_addr_x), .mem_addr_y(b_mem_addr_y),
        .mem_wdata(b_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld),
        .busy(b_busy), .occ(b_occ), .err_tmo(b_err_tmo)
    );

    task automatic do_push(input logic [DW-1:0] d, input int ack_dly);
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        ex = XW'(ptr * 5 + 3);
        ey = YW'(ptr + 100);
        @(negedge clk); push_req = 1'b1; push_data = d; #1;
        checks++; if (push_rdy !== 1'b1) begin failures++; $display("FAIL push_rdy act=%b exp=1", push_rdy); end
        @(negedge clk); push_req = 1'b0; push_data = $urandom;
        for (int i = 0; i <= ack_dly; i++) begin
            if (i > 0) @(negedge clk);
            mem_ack = (i == ack_dly); #1;
            checks++;
            if ({mem_req, mem_wr, mem_addr_y, mem_addr_x, mem_wdata} !== {1'b1, 1'b1, ey, ex, d}) begin
                failures++;
                $display("FAIL wr_req act=%b%b y=%0d x=%0d d=%h exp=11 y=%0d x=%0d d=%h",
                         mem_req, mem_wr, mem_addr_y, mem_addr_x, mem_wdata, ey, ex, d);
            end
            checks++;
            if ({lf_wr_en, lf_rd_en} !== {(i == ack_dly), 1'b0}) begin
                failures++; $display("FAIL lf_wr_en cyc=%0d act=%b%b exp=%b0", i, lf_wr_en, lf_rd_en, (i == ack_dly));
            end
        end
        sram[{mem_addr_y, mem_addr_x}] = mem_wdata;
        @(negedge clk); mem_ack = 1'b0; ptr++; model_q.push_back(d); #1;
        checks++;
        if ({mem_req, lf_wr_en, busy} !== 3'b000 || occ !== OW'(model_q.size())) begin
            failures++; $display("FAIL push_done req/wr_en/busy=%b%b%b occ=%0d exp=000 occ=%0d",
                                 mem_req, lf_wr_en, busy, occ, model_q.size());
        end
    endtask

    task automatic do_pop(input int ack_dly, input int rd_dly, input bit tmo, input bit with_push);
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [19:0]   key;
        logic [DW-1:0] exp_d;
        ex = XW'((ptr - 1) * 5 + 3);
        ey = YW'(ptr - 1 + 100);
        @(negedge clk); pop_req = 1'b1; push_req = with_push; push_data = $urandom; #1;
        checks++;
        if ({pop_rdy, push_rdy} !== 2'b10) begin
            failures++; $display("FAIL pop_accept pop_rdy/push_rdy act=%b%b exp=10", pop_rdy, push_rdy);
        end
        if (with_push) begin
            checks++;
            if ({b_pop_rdy, b_push_rdy} !== 2'b01) begin
                failures++; $display("FAIL prio0_rdy pop_rdy/push_rdy act=%b%b exp=01", b_pop_rdy, b_push_rdy);
            end
        end
        @(negedge clk); pop_req = 1'b0; push_req = 1'b0;
        if (with_push) begin
            #1; checks++;
            if ({b_mem_req, b_mem_wr} !== 2'b11) begin
                failures++; $display("FAIL prio0_served req/wr act=%b%b exp=11", b_mem_req, b_mem_wr);
            end
        end
        for (int i = 0; i <= ack_dly; i++) begin
            if (i > 0) @(negedge clk);
            mem_ack = (i == ack_dly);
            mem_rdata_vld = (i != ack_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom; #1;
            checks++;
            if ({mem_req, mem_wr, mem_addr_y, mem_addr_x} !== {1'b1, 1'b0, ey, ex}) begin
                failures++; $display("FAIL rd_req act=%b%b y=%0d x=%0d exp=10 y=%0d x=%0d",
                                     mem_req, mem_wr, mem_addr_y, mem_addr_x, ey, ex);
            end
            checks++;
            if ({lf_rd_en, lf_wr_en} !== {(i == ack_dly), 1'b0}) begin
                failures++; $display("FAIL lf_rd_en cyc=%0d act=%b%b exp=%b0", i, lf_rd_en, lf_wr_en, (i == ack_dly));
            end
        end
        key = {mem_addr_y, mem_addr_x};
        @(negedge clk); mem_ack = 1'b0; mem_rdata_vld = 1'b0; ptr--; exp_d = model_q.pop_back(); #1;
        checks++;
        if (occ !== OW'(model_q.size()) || {busy, mem_req, lf_rd_en} !== 3'b100) begin
            failures++; $display("FAIL rd_wait occ=%0d busy/req/rd_en=%b%b%b exp occ=%0d 100",
                                 occ, busy, mem_req, lf_rd_en, model_q.size());
        end
        if (!tmo) begin
            for (int i = 0; i <= rd_dly; i++) begin
                if (i > 0) @(negedge clk);
                mem_rdata_vld = (i == rd_dly);
                mem_rdata = (i == rd_dly) ? sram[key] : DW'($urandom); #1;
                checks++;
                if (pop_data_vld !== 1'b0) begin failures++; $display("FAIL early_vld cyc=%0d act=1 exp=0", i); end
            end
            @(negedge clk); mem_rdata_vld = 1'b0; mem_rdata = $urandom; #1;
            checks++;
            if (pop_data_vld !== 1'b1 || pop_data !== exp_d) begin
                failures++; $display("FAIL pop_data vld=%b d=%h exp vld=1 d=%h", pop_data_vld, pop_data, exp_d);
            end
            @(negedge clk); #1;
            checks++;
            if ({pop_data_vld, busy} !== 2'b00) begin
                failures++; $display("FAIL pop_end vld/busy act=%b%b exp=00", pop_data_vld, busy);
            end
        end else begin
            for (int i = 1; i <= TMO + 3; i++) begin
                @(negedge clk); #1;
                checks++;
                if (pop_data_vld !== 1'b0) begin failures++; $display("FAIL tmo_vld cyc=%0d act=1 exp=0", i); end
                if (i == TMO - 1) begin
                    checks++;
                    if ({err_tmo, busy} !== 2'b01) begin
                        failures++; $display("FAIL tmo_early err/busy act=%b%b exp=01", err_tmo, busy);
                    end
                end
            end
            checks++;
            if ({err_tmo, busy} !== 2'b10) begin
                failures++; $display("FAIL tmo_set err/busy act=%b%b exp=10", err_tmo, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_sync = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({busy, mem_req, mem_wr, lf_wr_en, lf_rd_en, pop_data_vld, err_tmo} !== 7'b0) begin
            failures++; $display("FAIL reset_ctl act=%b exp=0",
                                 {busy, mem_req, mem_wr, lf_wr_en, lf_rd_en, pop_data_vld, err_tmo});
        end
        checks++;
        if (pop_data !== '0 || mem_wdata !== '0) begin
            failures++; $display("FAIL reset_data pop=%h wd=%h exp=0", pop_data, mem_wdata);
        end
        checks++;
        if ({mem_addr_y, mem_addr_x} !== 20'd0 || occ !== '0) begin
            failures++; $display("FAIL reset_addr_occ a=%h occ=%0d exp=0", {mem_addr_y, mem_addr_x}, occ);
        end
        rst_sync = 1'b0; #1;
        checks++;
        if ({push_rdy, pop_rdy} !== 2'b10) begin
            failures++; $display("FAIL reset_rdy push/pop act=%b%b exp=10", push_rdy, pop_rdy);
        end
    endtask

    task automatic test_basic();
        do_push(32'hA5A5_0001, 0);
        do_pop(0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_lifo_order();
        do_push(32'h1, 0);
        do_push(32'h2, 1);
        do_push(32'h3, 0);
        repeat (3) do_pop(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        do_push($urandom, 0);
        do_pop(0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_full_empty_block();
        full_force = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); push_req = 1'b1; pop_req = (ptr == 0); push_data = $urandom; #1;
            checks++;
            if ({push_rdy, pop_rdy, mem_req, busy} !== 4'b0000) begin
                failures++; $display("FAIL blocked cyc=%0d push_rdy/pop_rdy/req/busy act=%b%b%b%b exp=0000",
                                     i, push_rdy, pop_rdy, mem_req, busy);
            end
        end
        @(negedge clk); push_req = 1'b0; pop_req = 1'b0; full_force = 1'b0;
        do_push(32'hF00D_0042, 0);
    endtask

    task automatic test_ack_hold();
        do_push($urandom, 5);
        do_pop(4, 2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if (ptr == 0 || (ptr < DEPTH && $urandom_range(0, 1) == 1)) do_push($urandom, $urandom_range(0, 3));
            else do_pop($urandom_range(0, 3), $urandom_range(0, 5), 1'b0, 1'b0);
        end
    endtask

    task automatic test_timeout_reset();
        if (ptr < 2) do_push($urandom, 0);
        if (ptr < 2) do_push($urandom, 0);
        do_pop(1, 0, 1'b1, 1'b0);
        @(negedge clk); push_req = 1'b1; push_data = $urandom;
        @(negedge clk); push_req = 1'b0; #1;
        checks++;
        if ({mem_req, mem_wr} !== 2'b11) begin
            failures++; $display("FAIL rst_pre req/wr act=%b%b exp=11", mem_req, mem_wr);
        end
        rst_sync = 1'b1;
        @(negedge clk); rst_sync = 1'b0; mem_ack = 1'b1; #1;
        checks++;
        if ({lf_wr_en, mem_req, busy, err_tmo} !== 4'b0000 || occ !== '0) begin
            failures++; $display("FAIL rst_abandon wr_en/req/busy/err=%b%b%b%b occ=%0d exp=0000 occ=0",
                                 lf_wr_en, mem_req, busy, err_tmo, occ);
        end
        @(negedge clk); mem_ack = 1'b0; ptr = 0; model_q.delete(); #1;
        checks++;
        if ({lf_wr_en, busy} !== 2'b00) begin
            failures++; $display("FAIL rst_after wr_en/busy act=%b%b exp=00", lf_wr_en, busy);
        end
    endtask

    initial begin
        rst_sync = 1'b1; push_req = 1'b0; pop_req = 1'b0; push_data = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_rdata_vld = 1'b0;
        test_reset();
        test_basic();
        test_lifo_order();
        test_priority();
        test_full_empty_block();
        test_ack_hold();
        test_random();
        test_timeout_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syn_gpu_ff_stack_sched.md
Name: syn_gpu_ff_stack_sched

Overview:
- Sequencer for the GPU fill-stack (LIFO held in SRAM above the frame buffer).
- Accepts push/pop requests from the flood-fill engine and drives the LIFO pointer controller's wr_en/rd_en.
- Issues the matching single-word SRAM write/read at the pointer address, waits for the SRAM grant and read data, and returns popped entries.
- Sits between the fill engine, the LIFO pointer controller and the SRAM arbiter port.

Parameters:
- P_X_W, 10, width of x coordinate of SRAM address.
- P_Y_W, 10, width of y coordinate of SRAM address.
- P_DATA_W, 32, stack entry width (one SRAM word).
- P_OCC_W, 16, occupancy counter width.
- P_POP_PRIO, 1, 1: pop wins a simultaneous push/pop in IDLE; 0: push wins.
- P_RD_TMO, 255, maximum cycles from read grant to mem_rdata_vld before a timeout error.

Ports:
- clk_ir in 1: clock.
- rst_sync in 1: synchronous active-high reset.
- push_req in 1: push valid.
- push_data in P_DATA_W: entry to push.
- push_rdy out 1: push accepted when push_req & push_rdy.
- pop_req in 1: pop request.
- pop_rdy out 1: pop accepted when pop_req & pop_rdy.
- pop_data out P_DATA_W: popped entry.
- pop_data_vld out 1: single-cycle strobe qualifying pop_data.
- lf_wr_en out 1: single-cycle pulse that advances the LIFO pointer (push).
- lf_rd_en out 1: single-cycle pulse that retracts the LIFO pointer (pop).
- lf_waddr_x/lf_waddr_y in P_X_W/P_Y_W: next write address from the LIFO controller.
- lf_raddr_x/lf_raddr_y in P_X_W/P_Y_W: top-of-stack read address.
- lf_full in 1: LIFO full flag.
- lf_empty in 1: LIFO empty flag.
- mem_req out 1: SRAM request, held until mem_ack.
- mem_wr out 1: 1 = write, 0 = read.
- mem_addr_x/mem_addr_y out P_X_W/P_Y_W: SRAM address.
- mem_wdata out P_DATA_W: SRAM write data.
- mem_ack in 1: SRAM grant; the transfer occurs on the cycle mem_req & mem_ack.
- mem_rdata in P_DATA_W: SRAM read data.
- mem_rdata_vld in 1: qualifies mem_rdata.
- busy out 1: state != IDLE.
- occ out P_OCC_W: number of entries on the stack.
- err_tmo out 1: sticky read-timeout error.

Behaviour:
- Reset (rst_sync=1 at a clock edge) values:
  - State: IDLE.
  - All request and strobe outputs: 0.
  - pop_data, mem_wdata, mem_addr: 0.
  - occ: 0.
  - err_tmo: 0.
  - Reset mid-transaction abandons it; no lf_wr_en/lf_rd_en is issued afterwards.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT.
- Ready signals are combinational and only asserted in IDLE:
  - push_rdy = IDLE & ~lf_full & ~(P_POP_PRIO & pop_req & ~lf_empty).
  - pop_rdy = IDLE & ~lf_empty & ~(~P_POP_PRIO & push_req & ~lf_full).
- Push accepted:
  - Latch push_data into mem_wdata and lf_waddr into mem_addr.
  - Next cycle: mem_req=1, mem_wr=1 (WR_REQ).
  - On mem_ack: one-cycle lf_wr_en pulse, occ+1, return to IDLE.
  - Minimum push cost 2 cycles (accept plus a same-cycle grant).
- Pop accepted:
  - Latch lf_raddr into mem_addr; enter RD_REQ with mem_req=1, mem_wr=0.
  - On mem_ack: lf_rd_en pulse, occ-1, go to RD_WAIT and start the timeout counter.
  - In RD_WAIT, on mem_rdata_vld: register mem_rdata into pop_data, pulse pop_data_vld the next cycle, return to IDLE.
- Read timeout: counter reaches P_RD_TMO without mem_rdata_vld -> set err_tmo, return to IDLE with no pop_data_vld. err_tmo clears only on reset.
- mem_req, mem_wr, mem_addr and mem_wdata are stable from assertion until mem_ack. mem_req deasserts the cycle after ack.
- Boundary conditions:
  - lf_full blocks push; lf_empty blocks pop. Requests simply stall; no error is raised.
  - lf_wr_en and lf_rd_en are never asserted in the same cycle.
  - occ saturates at 0 and 2^P_OCC_W-1.
  - mem_rdata_vld outside RD_WAIT is ignored.
  - Push and pop are serialized: only one transaction is outstanding at a time.

Decomposition:
- Shared syn_gpu_pkg:
  - FSM enum type ff_sched_st_t.
  - Defaults for the coordinate and data widths.
- No sub-module. The timeout counter and occupancy counter are inline.

Test Plan:
- Push then pop, mem_ack on the first request cycle:
  - push 0xA5A5_0001 -> mem_wr=1 at lf_waddr, lf_wr_en pulse, occ=1.
  - pop, mem_rdata=0xA5A5_0001 after 2 cycles -> pop_data_vld with 0xA5A5_0001, occ=0.
- Push three entries (0x1, 0x2, 0x3), then three pops -> returned in order 0x3, 0x2, 0x1; busy=0 at the end.
- Simultaneous push_req and pop_req with occ=1:
  - P_POP_PRIO=1: pop served first (pop_rdy=1, push_rdy=0).
  - P_POP_PRIO=0: push served first.
- lf_full=1 with push_req held 10 cycles -> push_rdy=0, no mem_req; deassert lf_full -> push completes.
- mem_ack withheld 5 cycles during a write -> mem_req, mem_addr and mem_wdata stable; lf_wr_en fires exactly once after ack.
- Read with no mem_rdata_vld for P_RD_TMO=8 cycles -> err_tmo=1, state IDLE, no pop_data_vld; assert rst_sync -> err_tmo=0, occ=0.
